arrow_scheduler: RTL and testbench

Owns a pool of NUM_SLOTS arrow sprite instances and is the only block that drives their valid/speed/direction inputs. It accepts spawn requests from the chart/beat sequencer and allocates the lowest free slot. It retires slots on a player hit (oldest matching direction) or on lifetime expiry (miss), and counts both outcomes. It also composites the per-slot sprite pixels into one pixel stream for the video mixer.

---
 rtl/arrow_pkg.sv | 22 ++
 rtl/arrow_slot_pick.sv | 29 ++
 rtl/arrow_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_arrow_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
// Shared constants and types for the arrow scheduler and its helper selector.
// Direction codes are fixed by the sprite instances and the controller decoder.
package arrow_pkg;

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ACTIVE = 2'd1,
    COOL   = 2'd2
  } slot_state_t;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_LIFETIME  = 188;

  localparam int H_PIXELS = 1280;
  localparam int V_PIXELS = 720;

endpackage

// File: rtl/arrow_slot_pick.sv
// Combinational selector: index of the masked slot with the largest age, ties to
// the lower index. With all ages tied to zero it degenerates to lowest-set-bit.
module arrow_slot_pick #(
  parameter int N     = 4,
  parameter int AGE_W = 8
) (
  input  logic [N-1:0]       i_mask,
  input  logic [N*AGE_W-1:0] i_ages,
  output logic               o_found,
  output logic [2:0]         o_index
);

  logic [AGE_W-1:0] w_best;

  always_comb begin
    o_found = 1'b0;
    o_index = 3'd0;
    w_best  = '0;
    // Strict greater-than keeps the earlier (lower) index on equal ages.
    for (int i = 0; i < N; i++) begin
      if (i_mask[i] && (!o_found || (i_ages[i*AGE_W +: AGE_W] > w_best))) begin
        o_found = 1'b1;
        o_index = 3'(i);
        w_best  = i_ages[i*AGE_W +: AGE_W];
      end
    end
  end

endmodule

// File: rtl/arrow_scheduler.sv
// Arrow sprite pool: allocates slots on spawn, retires them on hit or lifetime
// expiry, counts both outcomes, and composites the per-slot sprite pixels.
module arrow_scheduler
  import arrow_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int LIFETIME  = DEF_LIFETIME,
  parameter int AGE_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   spawn_valid_in,
  output logic                   spawn_ready_out,
  input  logic [1:0]             spawn_direction_in,
  input  logic [2:0]             spawn_speed_in,
  input  logic                   hit_valid_in,
  input  logic [1:0]             hit_direction_in,
  output logic                   hit_ack_out,
  output logic                   hit_matched_out,
  output logic [2:0]             hit_slot_out,
  output logic [NUM_SLOTS-1:0]   slot_valid_out,
  output logic [2*NUM_SLOTS-1:0] slot_direction_out,
  output logic [3*NUM_SLOTS-1:0] slot_speed_out,
  input  logic [12*NUM_SLOTS-1:0] slot_pixel_in,
  input  logic [NUM_SLOTS-1:0]   slot_pixel_valid_in,
  output logic [11:0]            pixel_out,
  output logic                   pixel_valid_out,
  output logic [7:0]             hit_count_out,
  output logic [7:0]             miss_count_out
);

  localparam logic [AGE_W-1:0] LAST_AGE = AGE_W'(LIFETIME - 1);

  slot_state_t      r_state [NUM_SLOTS];
  logic [AGE_W-1:0] r_age   [NUM_SLOTS];
  logic [1:0]       r_dir   [NUM_SLOTS];
  logic [2:0]       r_speed [NUM_SLOTS];
  logic             r_origin_d;
  logic             r_hit_ack, r_hit_matched;
  logic [2:0]       r_hit_slot;
  logic [7:0]       r_hit_count, r_miss_count;
  logic [11:0]      r_pixel;
  logic             r_pixel_valid;

  logic [NUM_SLOTS-1:0]       w_free, w_active, w_hit_mask, w_expire;
  logic [NUM_SLOTS*AGE_W-1:0] w_ages;
  logic                       w_alloc_found, w_hit_found, w_pix_found;
  logic [2:0]                 w_alloc_idx, w_hit_idx, w_pix_idx;
  logic                       w_tick, w_spawn_fire, w_hit_take;
  logic [3:0]                 w_miss_n;
  logic [8:0]                 w_miss_sum;
  logic [11:0]                w_pix_data;

  always_comb begin
    w_free     = '0;
    w_active   = '0;
    w_hit_mask = '0;
    w_ages     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_free[i]                  = (r_state[i] == FREE);
      w_active[i]                = (r_state[i] == ACTIVE);
      w_hit_mask[i]              = (r_state[i] == ACTIVE) && (r_dir[i] == hit_direction_in);
      w_ages[i*AGE_W +: AGE_W]   = r_age[i];
    end
  end

  arrow_slot_pick #(.N(NUM_SLOTS), .AGE_W(AGE_W)) u_alloc_pick (
    .i_mask (w_free),
    .i_ages ('0),
    .o_found(w_alloc_found),
    .o_index(w_alloc_idx)
  );

  arrow_slot_pick #(.N(NUM_SLOTS), .AGE_W(AGE_W)) u_hit_pick (
    .i_mask (w_hit_mask),
    .i_ages (w_ages),
    .o_found(w_hit_found),
    .o_index(w_hit_idx)
  );

  arrow_slot_pick #(.N(NUM_SLOTS), .AGE_W(AGE_W)) u_pix_pick (
    .i_mask (slot_pixel_valid_in & w_active),
    .i_ages ('0),
    .o_found(w_pix_found),
    .o_index(w_pix_idx)
  );

  // Spawn handshake: transfer happens on any edge where valid && ready; the
  // requester holds valid and payload until then. Ready is low during reset.
  assign spawn_ready_out = rst_n & (|w_free);
  assign w_spawn_fire    = spawn_valid_in & spawn_ready_out & w_alloc_found;
  assign w_hit_take      = hit_valid_in & w_hit_found;
  assign w_tick          = (hcount_in == 11'd0) && (vcount_in == 10'd0) && !r_origin_d;

  // A hit on the same slot pre-empts its timeout.
  always_comb begin
    w_expire   = '0;
    w_miss_n   = '0;
    w_pix_data = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_expire[i] = w_active[i] && w_tick && (r_age[i] == LAST_AGE) &&
                    !(w_hit_take && (w_hit_idx == 3'(i)));
      w_miss_n    = w_miss_n + {3'b000, w_expire[i]};
      if (w_pix_idx == 3'(i)) w_pix_data = slot_pixel_in[i*12 +: 12];
    end
  end

  assign w_miss_sum = {1'b0, r_miss_count} + {5'b00000, w_miss_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= FREE;
        r_age[i]   <= '0;
        r_dir[i]   <= 2'd0;
        r_speed[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        case (r_state[i])
          FREE: begin
            if (w_spawn_fire && (w_alloc_idx == 3'(i))) begin
              r_state[i] <= ACTIVE;
              r_age[i]   <= '0;
              r_dir[i]   <= spawn_direction_in;
              r_speed[i] <= spawn_speed_in;
            end
          end
          ACTIVE: begin
            if ((w_hit_take && (w_hit_idx == 3'(i))) || w_expire[i]) r_state[i] <= COOL;
            else if (w_tick) r_age[i] <= r_age[i] + AGE_W'(1);
          end
          default: r_state[i] <= FREE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_origin_d    <= 1'b0;
      r_hit_ack     <= 1'b0;
      r_hit_matched <= 1'b0;
      r_hit_slot    <= 3'd0;
      r_hit_count   <= 8'd0;
      r_miss_count  <= 8'd0;
      r_pixel       <= 12'd0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_origin_d    <= (hcount_in == 11'd0) && (vcount_in == 10'd0);
      r_hit_ack     <= hit_valid_in;
      r_hit_matched <= w_hit_take;
      r_hit_slot    <= w_hit_take ? w_hit_idx : 3'd0;
      if (w_hit_take && (r_hit_count != 8'hFF)) r_hit_count <= r_hit_count + 8'd1;
      r_miss_count  <= w_miss_sum[8] ? 8'hFF : w_miss_sum[7:0];
      r_pixel       <= w_pix_found ? w_pix_data : 12'd0;
      r_pixel_valid <= w_pix_found;
    end
  end

  always_comb begin
    slot_direction_out = '0;
    slot_speed_out     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_direction_out[2*i +: 2] = r_dir[i];
      slot_speed_out[3*i +: 3]     = r_speed[i];
    end
  end

  assign slot_valid_out  = w_active;
  assign hit_ack_out     = r_hit_ack;
  assign hit_matched_out = r_hit_matched;
  assign hit_slot_out    = r_hit_slot;
  assign hit_count_out   = r_hit_count;
  assign miss_count_out  = r_miss_count;
  assign pixel_out       = r_pixel;
  assign pixel_valid_out = r_pixel_valid;

endmodule

// File: tb/tb_arrow_scheduler.sv
// Bench for arrow_scheduler: directed sequences and a pixel vector table on top
// of a cycle-level reference model that checks every output on every cycle.
module tb_arrow_scheduler;
  import arrow_pkg::*;

  localparam int NS = 4;
  localparam int LT = 188;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic             spawn_valid_in, spawn_ready_out;
  logic [1:0]       spawn_direction_in;
  logic [2:0]       spawn_speed_in;
  logic             hit_valid_in;
  logic [1:0]       hit_direction_in;
  logic             hit_ack_out, hit_matched_out;
  logic [2:0]       hit_slot_out;
  logic [NS-1:0]    slot_valid_out;
  logic [2*NS-1:0]  slot_direction_out;
  logic [3*NS-1:0]  slot_speed_out;
  logic [12*NS-1:0] slot_pixel_in;
  logic [NS-1:0]    slot_pixel_valid_in;
  logic [11:0]      pixel_out;
  logic             pixel_valid_out;
  logic [7:0]       hit_count_out, miss_count_out;

  arrow_scheduler #(.NUM_SLOTS(NS), .LIFETIME(LT), .AGE_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .spawn_valid_in(spawn_valid_in), .spawn_ready_out(spawn_ready_out),
    .spawn_direction_in(spawn_direction_in), .spawn_speed_in(spawn_speed_in),
    .hit_valid_in(hit_valid_in), .hit_direction_in(hit_direction_in),
    .hit_ack_out(hit_ack_out), .hit_matched_out(hit_matched_out), .hit_slot_out(hit_slot_out),
    .slot_valid_out(slot_valid_out), .slot_direction_out(slot_direction_out),
    .slot_speed_out(slot_speed_out), .slot_pixel_in(slot_pixel_in),
    .slot_pixel_valid_in(slot_pixel_valid_in), .pixel_out(pixel_out),
    .pixel_valid_out(pixel_valid_out), .hit_count_out(hit_count_out),
    .miss_count_out(miss_count_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Slot status: 0 = free, 1 = holding an arrow, 2 = one-cycle cooldown.
  int          m_state [NS];
  int          m_age   [NS];
  logic [1:0]  m_dir   [NS];
  logic [2:0]  m_spd   [NS];
  int          m_hits, m_miss;
  logic [11:0] m_pix;
  logic        m_pixv;
  bit          m_prev_origin;
  logic [3:0]  exp_q[$];   // {matched, slot} for each pending hit response

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_state[i] = 0; m_age[i] = 0; m_dir[i] = 2'd0; m_spd[i] = 3'd0;
    end
    m_hits = 0; m_miss = 0; m_pix = 12'd0; m_pixv = 1'b0; m_prev_origin = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_compare();
    logic [NS-1:0] ev;
    logic          any_free;
    logic [3:0]    e;
    ev = '0; any_free = 1'b0;
    for (int i = 0; i < NS; i++) begin
      ev[i] = (m_state[i] == 1);
      if (m_state[i] == 0) any_free = 1'b1;
    end
    check("slot_valid", slot_valid_out, ev);
    check("spawn_ready", spawn_ready_out, rst_n && any_free);
    for (int i = 0; i < NS; i++) begin
      if (m_state[i] == 1) begin
        check("slot_dir", slot_direction_out[2*i +: 2], m_dir[i]);
        check("slot_speed", slot_speed_out[3*i +: 3], m_spd[i]);
      end
    end
    check("pixel", pixel_out, m_pix);
    check("pixel_valid", pixel_valid_out, m_pixv);
    check("hit_count", hit_count_out, m_hits);
    check("miss_count", miss_count_out, m_miss);
    check("hit_ack", hit_ack_out, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("hit_matched", hit_matched_out, e[3]);
      if (e[3]) check("hit_slot", hit_slot_out, e[2:0]);
    end
  endtask

  task automatic model_step();
    bit origin, tick;
    int best, alloc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    origin = (hcount_in == 0) && (vcount_in == 0);
    tick = origin && !m_prev_origin;
    m_prev_origin = origin;
    // Composite: scan downward so the lowest covering active slot is the last writer.
    m_pix = 12'd0; m_pixv = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (slot_pixel_valid_in[i] && m_state[i] == 1) begin
        m_pix = slot_pixel_in[12*i +: 12]; m_pixv = 1'b1;
      end
    end
    best = -1;
    if (hit_valid_in) begin
      for (int i = 0; i < NS; i++)
        if (m_state[i] == 1 && m_dir[i] == hit_direction_in && (best < 0 || m_age[i] > m_age[best]))
          best = i;
      exp_q.push_back(best >= 0 ? {1'b1, 3'(best)} : 4'h0);
    end
    alloc = -1;
    for (int i = 0; i < NS; i++) if (alloc < 0 && m_state[i] == 0) alloc = i;
    if (!spawn_valid_in) alloc = -1;
    for (int i = 0; i < NS; i++) begin
      case (m_state[i])
        2: m_state[i] = 0;
        1: begin
          if (i == best) begin
            m_state[i] = 2;
            if (m_hits < 255) m_hits++;
          end else if (tick) begin
            if (m_age[i] == LT - 1) begin
              m_state[i] = 2;
              if (m_miss < 255) m_miss++;
            end else m_age[i]++;
          end
        end
        default: if (i == alloc) begin
          m_state[i] = 1; m_age[i] = 0; m_dir[i] = spawn_direction_in; m_spd[i] = spawn_speed_in;
        end
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set at posedge+1; outputs are compared at the following negedge.
  task automatic cycle();
    @(negedge clk);
    model_compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    spawn_valid_in = 1'b0; spawn_direction_in = DIR_DOWN; spawn_speed_in = 3'd0;
    hit_valid_in = 1'b0; hit_direction_in = DIR_DOWN;
    hcount_in = 11'd5; vcount_in = 10'd3;
    slot_pixel_in = '0; slot_pixel_valid_in = '0;
  endtask

  task automatic spawn(input logic [1:0] dir, input logic [2:0] spd);
    spawn_valid_in = 1'b1; spawn_direction_in = dir; spawn_speed_in = spd;
    cycle();
    spawn_valid_in = 1'b0;
  endtask

  task automatic hit(input logic [1:0] dir);
    hit_valid_in = 1'b1; hit_direction_in = dir;
    cycle();
    hit_valid_in = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      hcount_in = 11'd0; vcount_in = 10'd0;
      cycle();
      hcount_in = 11'd5; vcount_in = 10'd3;
      cycle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [NS-1:0]    pv;
    logic [12*NS-1:0] pix;
    logic [11:0]      exp_pix;
    logic             exp_v;
  } pix_vec_t;

  pix_vec_t   vecs[6];
  logic [1:0] fill_dir[5];

  initial begin
    vecs[0] = '{4'b0101, {12'hABC, 12'h0F0, 12'h00F, 12'hF00}, 12'hF00, 1'b1};
    vecs[1] = '{4'b0100, {12'hABC, 12'h0F0, 12'h00F, 12'hF00}, 12'h0F0, 1'b1};
    vecs[2] = '{4'b1000, {12'hABC, 12'h0F0, 12'h00F, 12'hF00}, 12'h000, 1'b0};
    vecs[3] = '{4'b0000, {12'hABC, 12'h0F0, 12'h00F, 12'hF00}, 12'h000, 1'b0};
    vecs[4] = '{4'b1110, {12'hABC, 12'h0F0, 12'h00F, 12'hF00}, 12'h00F, 1'b1};
    vecs[5] = '{4'b1111, {12'h123, 12'h456, 12'h789, 12'hDEF}, 12'hDEF, 1'b1};
    fill_dir = '{DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT, DIR_RIGHT};

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    cycle();
    check("reset_valid", slot_valid_out, 0);
    check("reset_ready", spawn_ready_out, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", spawn_ready_out, 1);
    cycle();

    // Fill: four requests land on slots 0..3, the fifth waits.
    spawn_valid_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      spawn_direction_in = fill_dir[k];
      spawn_speed_in = 3'(k + 1);
      cycle();
      check("fill_valid", slot_valid_out, (k < 4) ? 4'((1 << (k + 1)) - 1) : 4'hF);
    end
    check("fill_ready", spawn_ready_out, 0);

    // Reuse: retire slot 2 while the fifth request is still pending.
    hit_valid_in = 1'b1; hit_direction_in = DIR_LEFT;
    cycle();
    hit_valid_in = 1'b0;
    check("reuse_ack", {hit_ack_out, hit_matched_out, hit_slot_out}, {2'b11, 3'd2});
    check("reuse_cool_valid", slot_valid_out, 4'b1011);
    check("reuse_cool_ready", spawn_ready_out, 0);
    cycle();
    check("reuse_free_valid", slot_valid_out, 4'b1011);
    check("reuse_free_ready", spawn_ready_out, 1);
    cycle();
    spawn_valid_in = 1'b0;
    check("reuse_realloc", slot_valid_out, 4'b1111);
    check("reuse_dir", slot_direction_out[5:4], DIR_RIGHT);

    // Asynchronous reset while all slots are busy.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_valid", slot_valid_out, 0);
    check("midreset_counts", {hit_count_out, miss_count_out}, 0);
    check("midreset_ready", spawn_ready_out, 0);
    cycle();
    rst_n = 1'b1;
    #1;
    check("midreset_release_ready", spawn_ready_out, 1);
    cycle();

    // Oldest-first: slot 1 UP age 10, slot 2 UP age 40, slot 0 DOWN age 40.
    spawn(DIR_DOWN, 3'd1);
    spawn(DIR_LEFT, 3'd2);
    spawn(DIR_UP, 3'd3);
    tick_n(30);
    hit(DIR_LEFT);
    cycle();
    spawn(DIR_UP, 3'd4);
    tick_n(10);
    hit(DIR_UP);
    check("oldest_ack", {hit_ack_out, hit_matched_out, hit_slot_out}, {2'b11, 3'd2});
    check("oldest_hit_count", hit_count_out, 2);
    hit(DIR_LEFT);
    check("nomatch_ack", {hit_ack_out, hit_matched_out}, 2'b10);

    // Slot 0 reaches its last frame; a hit in the same tick cycle wins.
    tick_n(147);
    check("collide_pre_valid", slot_valid_out[0], 1);
    hcount_in = 11'd0; vcount_in = 10'd0;
    hit(DIR_DOWN);
    hcount_in = 11'd5; vcount_in = 10'd3;
    check("collide_valid", slot_valid_out[0], 0);
    check("collide_hit_slot", {hit_matched_out, hit_slot_out}, {1'b1, 3'd0});
    check("collide_counts", {hit_count_out, miss_count_out}, {8'd3, 8'd0});
    cycle();

    // Plain lifetime expiry.
    do_reset();
    spawn(DIR_UP, 3'd7);
    tick_n(LT - 1);
    check("timeout_pre", {slot_valid_out[0], miss_count_out}, {1'b1, 8'd0});
    tick_n(1);
    check("timeout_post", {slot_valid_out[0], miss_count_out}, {1'b0, 8'd1});

    // Pixel vectors with slots 0..2 active and slot 3 free.
    do_reset();
    spawn(DIR_DOWN, 3'd1);
    spawn(DIR_UP, 3'd1);
    spawn(DIR_LEFT, 3'd1);
    for (int k = 0; k < 6; k++) begin
      slot_pixel_valid_in = vecs[k].pv;
      slot_pixel_in = vecs[k].pix;
      cycle();
      check("pix_vec", {pixel_valid_out, pixel_out}, {vecs[k].exp_v, vecs[k].exp_pix});
    end
    idle_inputs();
    cycle();

    // Random traffic: sparse hits first (timeouts happen), dense hits later.
    for (int n = 0; n < 3000; n++) begin
      spawn_valid_in = ($urandom_range(0, 2) == 0);
      spawn_direction_in = 2'($urandom_range(0, 3));
      spawn_speed_in = 3'($urandom_range(0, 7));
      hit_valid_in = (n < 1500) ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 2) == 0);
      hit_direction_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        hcount_in = 11'd0; vcount_in = 10'd0;
      end else begin
        hcount_in = 11'($urandom_range(1, H_PIXELS - 1));
        vcount_in = 10'($urandom_range(0, V_PIXELS - 1));
      end
      slot_pixel_valid_in = 4'($urandom_range(0, 15));
      slot_pixel_in = {16'($urandom), $urandom};
      cycle();
    end
    idle_inputs();

    // Hit counter saturation: one DOWN arrow spawned and hit every cycle.
    spawn_valid_in = 1'b1; spawn_direction_in = DIR_DOWN;
    hit_valid_in = 1'b1; hit_direction_in = DIR_DOWN;
    repeat (300) cycle();
    idle_inputs();
    cycle();
    check("hit_saturate", hit_count_out, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
